// File: rtl/demux_pkg.sv
// Shared constants and the per-channel FIFO state type for the one-to-two word demux.
package demux_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned COUNT_W       = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/word_fifo_two.sv
// Two-entry word FIFO: slot0 is always the head, slot1 the second word.
// A push while FULL is ignored; the caller must gate pushes with !full.
module word_fifo_two
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head_data
);

    fifo_state_t      state;
    fifo_state_t      state_next;
    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (state != FULL);
    assign pop_ok  = ready && (state != EMPTY);

    // State register; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode from push/pop events.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (push_ok) state_next = ONE;
            ONE: begin
                if (push_ok && !pop_ok)      state_next = FULL;
                else if (pop_ok && !push_ok) state_next = EMPTY;
            end
            FULL:    if (pop_ok) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Word storage; ONE with simultaneous push and pop overwrites the head in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case (state)
                EMPTY: if (push_ok) slot0 <= push_data;
                ONE: begin
                    if (push_ok && pop_ok) slot0 <= push_data;
                    else if (push_ok)      slot1 <= push_data;
                end
                FULL:    if (pop_ok) slot0 <= slot1;
                default: ;
            endcase
        end
    end

    // Status and head outputs; the head reads zero whenever nothing is stored.
    always_comb begin
        valid     = (state != EMPTY);
        full      = (state == FULL);
        head_data = (state != EMPTY) ? slot0 : '0;
    end

endmodule

// File: rtl/word_demux_one_to_two.sv
// Routes each source word to one of two independently buffered output channels.
// Optional macro DEMUX_COUNT_EN adds saturating 8-bit delivered-word counters per channel.
module word_demux_one_to_two
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    input  logic             in_valid,
    output logic             ou_ready,
    output logic [WIDTH-1:0] ou_data_one,
    output logic [WIDTH-1:0] ou_data_two,
    output logic             ou_valid_one,
    output logic             ou_valid_two,
    input  logic             in_ready_one,
    input  logic             in_ready_two
`ifdef DEMUX_COUNT_EN
    ,
    output logic [COUNT_W-1:0] ou_count_one,
    output logic [COUNT_W-1:0] ou_count_two
`endif
);

    logic full_one;
    logic full_two;
    logic push_one;
    logic push_two;

    // Ready follows the selected channel only; a FULL channel is never bypassed.
    always_comb begin
        ou_ready = in_select ? !full_two : !full_one;
        push_one = in_valid && ou_ready && !in_select;
        push_two = in_valid && ou_ready &&  in_select;
    end

    word_fifo_two #(.WIDTH(WIDTH)) u_fifo_one (
        .clk       (in_clk),
        .rst_n     (in_rst_n),
        .push      (push_one),
        .push_data (in_data),
        .ready     (in_ready_one),
        .full      (full_one),
        .valid     (ou_valid_one),
        .head_data (ou_data_one)
    );

    word_fifo_two #(.WIDTH(WIDTH)) u_fifo_two (
        .clk       (in_clk),
        .rst_n     (in_rst_n),
        .push      (push_two),
        .push_data (in_data),
        .ready     (in_ready_two),
        .full      (full_two),
        .valid     (ou_valid_two),
        .head_data (ou_data_two)
    );

`ifdef DEMUX_COUNT_EN
    logic pop_one;
    logic pop_two;

    assign pop_one = ou_valid_one && in_ready_one;
    assign pop_two = ou_valid_two && in_ready_two;

    // Delivered-word counters, saturating at all-ones.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            ou_count_one <= '0;
            ou_count_two <= '0;
        end else begin
            if (pop_one && (ou_count_one != '1)) ou_count_one <= ou_count_one + COUNT_W'(1);
            if (pop_two && (ou_count_two != '1)) ou_count_two <= ou_count_two + COUNT_W'(1);
        end
    end
`endif

endmodule
